pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 33 +++
 rtl/pipe_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: hazard inputs, stall/flush requests and stall/flush outputs.
interface pipe_ctrl_if;
  localparam int unsigned RA_W = 5;
  localparam int unsigned ST_W = 3;

  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic            id_uses_rt;
  logic            ex_is_load;
  logic [RA_W-1:0] ex_rd;
  logic            ex_rf_we;
  logic            div_req;
  logic            mem_req;
  logic            mem_data_ok;
  logic            exc_valid;
  logic            hazard_stall;
  logic            exe_stall;
  logic            if_stall;
  logic            int_flush;
  logic [ST_W-1:0] ctrl_state;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_is_load, ex_rd, ex_rf_we,
           div_req, mem_req, mem_data_ok, exc_valid,
    input  hazard_stall, exe_stall, if_stall, int_flush, ctrl_state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_is_load, ex_rd, ex_rf_we,
           div_req, mem_req, mem_data_ok, exc_valid,
    output hazard_stall, exe_stall, if_stall, int_flush, ctrl_state
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, SRAM wait, divide freeze, exception flush.
// Divide sequencing is built only when PIPE_CTRL_DIV_EN is defined.
module pipe_ctrl #(
  parameter int unsigned DIV_CYCLES = 33
) (
  input  logic        clk,
  input  logic        resetn,
  pipe_ctrl_if.slave  bus
);
  localparam int unsigned ST_W  = 3;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [ST_W-1:0] {
    IDLE     = 3'd0,
    MEM_WAIT = 3'd1,
    DIV_BUSY = 3'd2,
    DIV_DONE = 3'd3,
    FLUSH    = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   pend_q, pend_d;
  logic   flush_q, flush_d;
  logic   exe_stall_c;
  logic   mem_miss_c;
  logic   ld_hit_c;
  logic   haz_c;

`ifdef PIPE_CTRL_DIV_EN
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  logic unused_div;
  assign unused_div = bus.div_req ^ (DIV_CYCLES == 0);
`endif

  // State, pending-exception flag and registered flush pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      flush_q <= flush_d;
    end
  end

  assign mem_miss_c = bus.mem_req & ~bus.mem_data_ok;

  // Next state and EX freeze
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    exe_stall_c = 1'b0;
`ifdef PIPE_CTRL_DIV_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.exc_valid) begin
          state_d = FLUSH;
        end else if (mem_miss_c) begin
          state_d     = MEM_WAIT;
          exe_stall_c = 1'b1;
        end
`ifdef PIPE_CTRL_DIV_EN
        else if (bus.div_req) begin
          state_d     = DIV_BUSY;
          cnt_d       = CNT_LOAD;
          exe_stall_c = 1'b1;
        end
`endif
      end
      // The bus access always completes; an exception is deferred until it does
      MEM_WAIT: begin
        exe_stall_c = ~bus.mem_data_ok;
        pend_d      = pend_q | bus.exc_valid;
        if (bus.mem_data_ok) state_d = (pend_q | bus.exc_valid) ? FLUSH : IDLE;
      end
`ifdef PIPE_CTRL_DIV_EN
      DIV_BUSY: begin
        exe_stall_c = 1'b1;
        if (bus.exc_valid) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = DIV_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DIV_DONE: state_d = bus.exc_valid ? FLUSH : IDLE;
`endif
      FLUSH: begin
        pend_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    flush_d = (state_d == FLUSH);
  end

  // Load-use hazard against the instruction in ID; r0 never hazards
  assign ld_hit_c = bus.ex_is_load & bus.ex_rf_we & (bus.ex_rd != 5'd0) &
                    ((bus.ex_rd == bus.id_rs) | (bus.id_uses_rt & (bus.ex_rd == bus.id_rt)));
  assign haz_c    = ld_hit_c & ~exe_stall_c & ~flush_q;

  assign bus.hazard_stall = haz_c;
  assign bus.exe_stall    = exe_stall_c;
  assign bus.if_stall     = haz_c | exe_stall_c;
  assign bus.int_flush    = flush_q;
  assign bus.ctrl_state   = state_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them.
module tb_pipe_ctrl;
  typedef struct {
    logic [95:0] tag;
    logic        haz;
    logic        exe;
    logic        fl;
    logic [2:0]  st;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  pipe_ctrl_if bus();

  pipe_ctrl #(.DIV_CYCLES(33)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  logic       h_ld, h_we, h_ut;
  logic [4:0] h_rd, h_rs, h_rt;

  task automatic chk1(input logic [95:0] tag, input string nm, input logic [2:0] act,
                      input logic [2:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s %s: got %0d want %0d", tag, nm, act, exp);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk1(e.tag, "hazard_stall", 3'(bus.hazard_stall), 3'(e.haz));
        chk1(e.tag, "exe_stall",    3'(bus.exe_stall),    3'(e.exe));
        chk1(e.tag, "if_stall",     3'(bus.if_stall),     3'(e.haz | e.exe));
        chk1(e.tag, "int_flush",    3'(bus.int_flush),    3'(e.fl));
        chk1(e.tag, "ctrl_state",   bus.ctrl_state,       e.st);
      end
    end
  end

  task automatic set_h(input logic ld, we, input logic [4:0] rd, rs, rt, input logic ut);
    h_ld = ld; h_we = we; h_rd = rd; h_rs = rs; h_rt = rt; h_ut = ut;
  endtask

  task automatic drive(input logic rst, mr, ok, dv, ex);
    resetn          = ~rst;
    bus.mem_req     = mr;
    bus.mem_data_ok = ok;
    bus.div_req     = dv;
    bus.exc_valid   = ex;
    bus.ex_is_load  = h_ld;
    bus.ex_rf_we    = h_we;
    bus.ex_rd       = h_rd;
    bus.id_rs       = h_rs;
    bus.id_rt       = h_rt;
    bus.id_uses_rt  = h_ut;
  endtask

  task automatic cyc(input logic [95:0] tag, input logic mr, ok, dv, ex,
                     input logic e_haz, e_exe, e_fl, input logic [2:0] e_st);
    exp_t e;
    @(posedge clk); #1;
    drive(1'b0, mr, ok, dv, ex);
    e.tag = tag; e.haz = e_haz; e.exe = e_exe; e.fl = e_fl; e.st = e_st;
    q.push_back(e);
  endtask

  // Reset asserted mid-cycle, so the negedge sample shows the asynchronous effect
  task automatic rst_cyc(input logic [95:0] tag, input logic e_haz);
    exp_t e;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    e.tag = tag; e.haz = e_haz; e.exe = 1'b0; e.fl = 1'b0; e.st = 3'd0;
    q.push_back(e);
  endtask

  initial begin
    set_h(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    set_h(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    rst_cyc("rst_haz", 1'b1);

    // Load-use detection in IDLE
    cyc("lu_rs", 0, 0, 0, 0, 1, 0, 0, 0);
    set_h(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0); cyc("lu_rd0",   0, 0, 0, 0, 0, 0, 0, 0);
    set_h(1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1); cyc("lu_rt",    0, 0, 0, 0, 1, 0, 0, 0);
    set_h(1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0); cyc("lu_rt_nu", 0, 0, 0, 0, 0, 0, 0, 0);
    set_h(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0); cyc("lu_noload",0, 0, 0, 0, 0, 0, 0, 0);
    set_h(1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0); cyc("lu_nowe",  0, 0, 0, 0, 0, 0, 0, 0);

    // SRAM wait, hazard suppressed while EX is frozen
    set_h(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    cyc("mw_c0", 1, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i < 4; i++) cyc("mw_wait", 0, 0, 0, 0, 0, 1, 0, 1);
    cyc("mw_ok",   0, 1, 0, 0, 1, 0, 0, 1);
    cyc("mw_idle", 0, 0, 0, 0, 1, 0, 0, 0);

    set_h(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc("mem_hit",  1, 1, 0, 0, 0, 0, 0, 0);
    cyc("mem_hit2", 0, 0, 0, 0, 0, 0, 0, 0);

    // Exception during SRAM wait is deferred until data returns
    set_h(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    cyc("pe_c0",    1, 0, 0, 0, 0, 1, 0, 0);
    cyc("pe_c1",    0, 0, 0, 0, 0, 1, 0, 1);
    cyc("pe_exc",   0, 0, 0, 1, 0, 1, 0, 1);
    cyc("pe_c3",    0, 0, 0, 0, 0, 1, 0, 1);
    cyc("pe_c4",    0, 0, 0, 0, 0, 1, 0, 1);
    cyc("pe_ok",    0, 1, 0, 0, 1, 0, 0, 1);
    cyc("pe_flush", 0, 0, 0, 0, 0, 0, 1, 4);
    cyc("pe_idle",  0, 0, 0, 0, 1, 0, 0, 0);

    // Exception in IDLE beats a memory miss
    set_h(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc("ie_exc",   1, 0, 0, 1, 0, 0, 0, 0);
    cyc("ie_flush", 0, 0, 0, 0, 0, 0, 1, 4);
    cyc("ie_idle",  0, 0, 0, 0, 0, 0, 0, 0);

    // Reset mid-wait drops the pending exception
    cyc("rm_c0",  1, 0, 0, 0, 0, 1, 0, 0);
    cyc("rm_exc", 0, 0, 0, 1, 0, 1, 0, 1);
    rst_cyc("rm_rst", 1'b0);
    cyc("rm_rel",  0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rm_c0b",  1, 0, 0, 0, 0, 1, 0, 0);
    cyc("rm_ok",   0, 1, 0, 0, 0, 0, 0, 1);
    cyc("rm_nofl", 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef PIPE_CTRL_DIV_EN
    // Full divide freeze: 33 stalled cycles then one DIV_DONE cycle
    cyc("dv_c0", 0, 0, 1, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 32; i++) cyc("dv_busy", 0, 0, 1, 0, 0, 1, 0, 2);
    cyc("dv_done", 0, 0, 1, 0, 0, 0, 0, 3);
    cyc("dv_idle", 0, 0, 0, 0, 0, 0, 0, 0);

    // Exception on divide cycle 10
    cyc("de_c0", 0, 0, 1, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 9; i++) cyc("de_busy", 0, 0, 1, 0, 0, 1, 0, 2);
    cyc("de_exc",   0, 0, 1, 1, 0, 1, 0, 2);
    cyc("de_flush", 0, 0, 0, 0, 0, 0, 1, 4);
    cyc("de_idle",  0, 0, 0, 0, 0, 0, 0, 0);

    // Memory wins over divide; divide starts once back in IDLE
    cyc("md_c0",   1, 0, 1, 0, 0, 1, 0, 0);
    cyc("md_wait", 0, 0, 1, 0, 0, 1, 0, 1);
    cyc("md_ok",   0, 1, 1, 0, 0, 0, 0, 1);
    cyc("md_div",  0, 0, 1, 0, 0, 1, 0, 0);
    cyc("md_busy", 0, 0, 1, 0, 0, 1, 0, 2);
    rst_cyc("dv_rst", 1'b0);
    cyc("dv_rel",  0, 0, 0, 0, 0, 0, 0, 0);

    // Exception in DIV_DONE
    cyc("dd_c0", 0, 0, 1, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 32; i++) cyc("dd_busy", 0, 0, 1, 0, 0, 1, 0, 2);
    cyc("dd_exc",   0, 0, 1, 1, 0, 0, 0, 3);
    cyc("dd_flush", 0, 0, 0, 0, 0, 0, 1, 4);
    cyc("dd_idle",  0, 0, 0, 0, 0, 0, 0, 0);
`else
    // Divide requests are ignored in this build
    cyc("nd_div",  0, 0, 1, 0, 0, 0, 0, 0);
    cyc("nd_div2", 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("nd_idle", 0, 0, 0, 0, 0, 0, 0, 0);
`endif

    @(posedge clk); #1;
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, want 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
